servo_pwm_multi: RTL and testbench



---
 rtl/servo_pkg.sv | 27 ++
 rtl/servo_pwm_timebase.sv | 51 +++++
 rtl/servo_pwm_multi.sv | 100 ++++++++++
 tb/tb_servo_pwm_multi.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared defaults and elaboration-time helpers for the multi-channel servo PWM controller.
package servo_pkg;

  localparam int ANGLE_MIN_DEF = 5;
  localparam int ANGLE_MAX_DEF = 25;
  localparam int ANGLE_RST_DEF = 5;

  // Clocks per angle unit; 64-bit math because CLK_HZ*UNIT_US overflows 32 bits.
  function automatic int tick_div(longint clk_hz, longint unit_us);
    return int'((clk_hz * unit_us) / 1_000_000);
  endfunction

  function automatic bit tick_div_exact(longint clk_hz, longint unit_us);
    return ((clk_hz * unit_us) % 1_000_000) == 0;
  endfunction

  function automatic int period_units(int period_us, int unit_us);
    return period_us / unit_us;
  endfunction

  function automatic int clamp_int(int v, int lo, int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/servo_pwm_timebase.sv
// Shared PWM timebase: prescaler, angle-unit counter, period start strobe and slew tick.
module servo_pwm_timebase #(
  parameter int TICK_DIV     = 50,
  parameter int PERIOD_UNITS = 200,
  parameter int SLEW_PERIODS = 1,
  localparam int PSC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1,
  localparam int UNIT_W = (PERIOD_UNITS > 1) ? $clog2(PERIOD_UNITS) : 1,
  localparam int SLEW_W = (SLEW_PERIODS > 1) ? $clog2(SLEW_PERIODS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic [UNIT_W-1:0] unit_cnt_o,
  output logic              period_start_o,
  output logic              slew_tick_o
);

  logic [PSC_W-1:0]  psc_q, psc_d;
  logic [UNIT_W-1:0] unit_q, unit_d;
  logic [SLEW_W-1:0] slew_q, slew_d;

  // Gated by rst so the strobe is low in reset and the first period begins on the release edge.
  assign period_start_o = !rst_i && (psc_q == '0) && (unit_q == '0);
  assign slew_tick_o    = period_start_o && (slew_q == SLEW_W'(SLEW_PERIODS - 1));
  assign unit_cnt_o     = unit_q;

  always_comb begin
    psc_d  = psc_q + PSC_W'(1);
    unit_d = unit_q;
    slew_d = slew_q;
    if (psc_q == PSC_W'(TICK_DIV - 1)) begin
      psc_d  = '0;
      unit_d = (unit_q == UNIT_W'(PERIOD_UNITS - 1)) ? '0 : unit_q + UNIT_W'(1);
    end
    if (period_start_o) begin
      slew_d = (slew_q == SLEW_W'(SLEW_PERIODS - 1)) ? '0 : slew_q + SLEW_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      psc_q  <= '0;
      unit_q <= '0;
      slew_q <= '0;
    end else begin
      psc_q  <= psc_d;
      unit_q <= unit_d;
      slew_q <= slew_d;
    end
  end

endmodule

// File: rtl/servo_pwm_multi.sv
// N-channel hobby-servo PWM: saturating targets, slew-limited current angles and
// period-boundary duty latching so every pulse is glitch-free.
module servo_pwm_multi
  import servo_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int CLK_HZ       = 50_000_000,
  parameter int UNIT_US      = 100,
  parameter int PERIOD_US    = 20000,
  parameter int ANGLE_W      = 8,
  parameter int ANGLE_MIN    = ANGLE_MIN_DEF,
  parameter int ANGLE_MAX    = ANGLE_MAX_DEF,
  parameter int ANGLE_RST    = ANGLE_RST_DEF,
  parameter int SLEW_PERIODS = 1,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          key_inc,
  input  logic [NUM_CH-1:0]          key_dec,
  input  logic                       load_valid,
  input  logic [CH_W-1:0]            load_ch,
  input  logic [ANGLE_W-1:0]         load_angle,
  output logic [NUM_CH*ANGLE_W-1:0]  angle_cur,
  output logic [NUM_CH-1:0]          busy,
  output logic                       period_start,
  output logic [NUM_CH-1:0]          pwm
);

  localparam int TICK_DIV     = tick_div(CLK_HZ, UNIT_US);
  localparam int PERIOD_UNITS = period_units(PERIOD_US, UNIT_US);
  localparam int UNIT_W       = (PERIOD_UNITS > 1) ? $clog2(PERIOD_UNITS) : 1;
  localparam logic [ANGLE_W-1:0] A_MIN = ANGLE_W'(ANGLE_MIN);
  localparam logic [ANGLE_W-1:0] A_MAX = ANGLE_W'(ANGLE_MAX);
  localparam logic [ANGLE_W-1:0] A_RST = ANGLE_W'(ANGLE_RST);

  if (TICK_DIV < 1 || !tick_div_exact(CLK_HZ, UNIT_US) || PERIOD_UNITS < 1 || SLEW_PERIODS < 1)
  begin : g_bad_cfg
    $error("servo_pwm_multi: CLK_HZ*UNIT_US must give an integer TICK_DIV >= 1");
  end

  logic [UNIT_W-1:0] unit_cnt;
  logic              slew_tick;

  servo_pwm_timebase #(
    .TICK_DIV    (TICK_DIV),
    .PERIOD_UNITS(PERIOD_UNITS),
    .SLEW_PERIODS(SLEW_PERIODS)
  ) u_timebase (
    .clk_i         (clk),
    .rst_i         (rst),
    .unit_cnt_o    (unit_cnt),
    .period_start_o(period_start),
    .slew_tick_o   (slew_tick)
  );

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [ANGLE_W-1:0] tgt_q, tgt_d, cur_q, cur_d, duty_q, duty_d;
    logic               pwm_q, busy_q;

    always_comb begin
      tgt_d = tgt_q;
      if (load_valid && load_ch == CH_W'(g)) begin
        tgt_d = ANGLE_W'(clamp_int(int'(load_angle), ANGLE_MIN, ANGLE_MAX));
      end else if (key_inc[g] && !key_dec[g] && tgt_q < A_MAX) begin
        tgt_d = tgt_q + ANGLE_W'(1);
      end else if (key_dec[g] && !key_inc[g] && tgt_q > A_MIN) begin
        tgt_d = tgt_q - ANGLE_W'(1);
      end

      cur_d = cur_q;
      if (slew_tick && cur_q < tgt_q) cur_d = cur_q + ANGLE_W'(1);
      else if (slew_tick && cur_q > tgt_q) cur_d = cur_q - ANGLE_W'(1);

      // The post-step angle is used for the very first unit of a new period too.
      duty_d = period_start ? cur_d : duty_q;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        tgt_q  <= A_RST;
        cur_q  <= A_RST;
        duty_q <= A_RST;
        pwm_q  <= 1'b0;
        busy_q <= 1'b0;
      end else begin
        tgt_q  <= tgt_d;
        cur_q  <= cur_d;
        duty_q <= duty_d;
        pwm_q  <= int'(unit_cnt) < int'(duty_d);
        busy_q <= cur_d != tgt_d;
      end
    end

    assign angle_cur[g*ANGLE_W +: ANGLE_W] = cur_q;
    assign busy[g] = busy_q;
    assign pwm[g]  = pwm_q;
  end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Bench for servo_pwm_multi: two instances (slew 1 and slew 3) against a cycle-count arithmetic model.
module tb_servo_pwm_multi;

  localparam int PER = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  a_inc = '0, a_dec = '0, b_inc = '0, b_dec = '0;
  logic        a_lv = 1'b0, b_lv = 1'b0, a_lch = 1'b0, b_lch = 1'b0;
  logic [7:0]  a_lang = '0, b_lang = '0;
  logic [15:0] a_ang, b_ang;
  logic [1:0]  a_busy, b_busy, a_pwm, b_pwm;
  logic        a_ps, b_ps;

  servo_pwm_multi #(.NUM_CH(2), .CLK_HZ(1_000_000), .UNIT_US(1), .PERIOD_US(200),
                    .SLEW_PERIODS(1)) dut_a (
    .clk(clk), .rst(rst), .key_inc(a_inc), .key_dec(a_dec), .load_valid(a_lv),
    .load_ch(a_lch), .load_angle(a_lang), .angle_cur(a_ang), .busy(a_busy),
    .period_start(a_ps), .pwm(a_pwm));

  servo_pwm_multi #(.NUM_CH(2), .CLK_HZ(1_000_000), .UNIT_US(1), .PERIOD_US(200),
                    .SLEW_PERIODS(3)) dut_b (
    .clk(clk), .rst(rst), .key_inc(b_inc), .key_dec(b_dec), .load_valid(b_lv),
    .load_ch(b_lch), .load_angle(b_lang), .angle_cur(b_ang), .busy(b_busy),
    .period_start(b_ps), .pwm(b_pwm));

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: e is the index of the next clock edge since reset release.
  int m_tgt[2][2], m_cur[2][2], m_duty[2][2];
  bit m_pwm[2][2];
  int e = 0;

  function automatic int next_tgt(int t, bit inc, bit dec, bit load, int lang);
    if (load) return (lang < 5) ? 5 : ((lang > 25) ? 25 : lang);
    if (inc && !dec) return (t < 25) ? t + 1 : t;
    if (dec && !inc) return (t > 5) ? t - 1 : t;
    return t;
  endfunction

  task automatic model_edge();
    logic [1:0] inc, dec;
    logic lv, lch;
    logic [7:0] lang;
    int slew;
    bit ps, tk;
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin inc = a_inc; dec = a_dec; lv = a_lv; lch = a_lch; lang = a_lang; slew = 1; end
      else        begin inc = b_inc; dec = b_dec; lv = b_lv; lch = b_lch; lang = b_lang; slew = 3; end
      ps = (e % PER) == 0;
      tk = ps && ((e / PER) % slew) == slew - 1;
      for (int c = 0; c < 2; c++) begin
        if (rst) begin
          m_tgt[d][c] = 5; m_cur[d][c] = 5; m_duty[d][c] = 5; m_pwm[d][c] = 1'b0;
        end else begin
          if (tk && m_cur[d][c] < m_tgt[d][c]) m_cur[d][c]++;
          else if (tk && m_cur[d][c] > m_tgt[d][c]) m_cur[d][c]--;
          m_tgt[d][c] = next_tgt(m_tgt[d][c], inc[c], dec[c], lv && (int'(lch) == c), int'(lang));
          if (ps) m_duty[d][c] = m_cur[d][c];
          m_pwm[d][c] = (e % PER) < m_duty[d][c];
        end
      end
    end
    e = rst ? 0 : e + 1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    for (int d = 0; d < 2; d++) begin
      exp_q.push_back(32'({m_pwm[d][1], m_pwm[d][0]}));
      exp_q.push_back(32'({m_cur[d][1] != m_tgt[d][1], m_cur[d][0] != m_tgt[d][0]}));
      exp_q.push_back(32'(m_cur[d][1] * 256 + m_cur[d][0]));
      exp_q.push_back(32'(!rst && (e % PER) == 0));
    end
    check("a_pwm",  32'(a_pwm),  exp_q.pop_front());
    check("a_busy", 32'(a_busy), exp_q.pop_front());
    check("a_ang",  32'(a_ang),  exp_q.pop_front());
    check("a_ps",   32'(a_ps),   exp_q.pop_front());
    check("b_pwm",  32'(b_pwm),  exp_q.pop_front());
    check("b_busy", 32'(b_busy), exp_q.pop_front());
    check("b_ang",  32'(b_ang),  exp_q.pop_front());
    check("b_ps",   32'(b_ps),   exp_q.pop_front());
    a_inc = '0; a_dec = '0; a_lv = 1'b0;
    b_inc = '0; b_dec = '0; b_lv = 1'b0;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // Reset, then idle: 5-clk pulses, period_start every 200 clks.
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    run(2 * PER);

    // 25 increments on ch0 saturate at 25; current slews over 20 periods.
    for (int i = 0; i < 25; i++) begin
      a_inc = 2'b01;
      tick();
      tick();
    end
    run(21 * PER);

    // Load clamping and simultaneous inc/dec.
    a_lv = 1'b1; a_lch = 1'b1; a_lang = 8'd200; tick();
    run(3);
    a_lv = 1'b1; a_lch = 1'b1; a_lang = 8'd2; tick();
    a_inc = 2'b10; a_dec = 2'b10; tick();
    a_inc = 2'b01; a_dec = 2'b01; tick();

    // Load beats key_dec; mid-period load leaves the running pulse alone.
    a_lv = 1'b1; a_lch = 1'b0; a_lang = 8'd10; a_dec = 2'b01; tick();
    while (e % PER != 50) tick();
    a_lv = 1'b1; a_lch = 1'b1; a_lang = 8'd20; tick();
    run(2 * PER);

    // Slew of 3 periods per unit on the second instance: 5 -> 8.
    b_lv = 1'b1; b_lch = 1'b0; b_lang = 8'd8; tick();
    run(10 * PER);
    run(5 * PER);

    // Reset at unit_cnt 2 with duty 10 on ch0.
    while (e % PER != 2) tick();
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    run(2 * PER);

    // Random key and load traffic on both instances.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) a_inc[$urandom_range(0, 1)] = 1'b1;
      if ($urandom_range(0, 15) == 0) a_dec[$urandom_range(0, 1)] = 1'b1;
      if ($urandom_range(0, 15) == 0) b_inc[$urandom_range(0, 1)] = 1'b1;
      if ($urandom_range(0, 15) == 0) b_dec[$urandom_range(0, 1)] = 1'b1;
      if ($urandom_range(0, 60) == 0) begin
        a_lv = 1'b1; a_lch = 1'($urandom_range(0, 1)); a_lang = 8'($urandom_range(0, 40));
      end
      if ($urandom_range(0, 60) == 0) begin
        b_lv = 1'b1; b_lch = 1'($urandom_range(0, 1)); b_lang = 8'($urandom_range(0, 255));
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
